// File: rtl/dili_decode_seq.sv
`timescale 1ns/1ps
// Job sequencer around the DILI sample decoder: latches config, pulses the decoder reset,
// streams host words in and buffers sample beats out. Optional checksum: DILI_SEQ_CHECKSUM_EN.
module dili_decode_seq #(
  parameter int OUTPUT_W = 4,
  parameter int COEFF_W  = 23,
  parameter int W        = 64,
  parameter int N_COEFF  = 256,
  parameter int NPOLY_W  = 4,
  parameter int RST_CYC  = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [2:0]                    sec_lvl_i,
  input  logic [2:0]                    encode_mode_i,
  input  logic [NPOLY_W-1:0]            num_poly_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [15:0]                   beat_cnt_o,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [W-1:0]                  in_data_i,
  output logic                          dec_rst_o,
  output logic [2:0]                    dec_sec_lvl_o,
  output logic [2:0]                    dec_mode_o,
  output logic                          dec_in_valid_o,
  input  logic                          dec_in_ready_i,
  output logic [W-1:0]                  dec_di_o,
  input  logic                          dec_out_valid_i,
  output logic                          dec_out_ready_o,
  input  logic [OUTPUT_W*COEFF_W-1:0]   dec_samples_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [OUTPUT_W*COEFF_W-1:0]   out_data_o,
  output logic                          out_last_o
`ifdef DILI_SEQ_CHECKSUM_EN
  ,
  output logic [31:0]                   chk_o
`endif
);

  localparam int DW   = OUTPUT_W * COEFF_W;
  localparam int BPP  = N_COEFF / OUTPUT_W;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int RC_W = $clog2(RST_CYC + 1);

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

  state_t            state;
  logic [15:0]       total;
  logic [15:0]       load_cnt;
  logic [RC_W-1:0]   rst_cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic              run;
  logic              dec_hs;
  logic              host_hs;

  // A zero polynomial count still runs one polynomial.
  function automatic logic [15:0] calc_total(input logic [NPOLY_W-1:0] n);
    logic [15:0] p;
    p = (n == '0) ? 16'd1 : 16'(n);
    return p * 16'(BPP);
  endfunction

`ifdef DILI_SEQ_CHECKSUM_EN
  function automatic logic [31:0] fold32(input logic [DW-1:0] d);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < DW; i++) f[i % 32] = f[i % 32] ^ d[i];
    return f;
  endfunction
`endif

  always_comb begin
    run             = (state == RUN);
    busy_o          = (state != IDLE);
    in_ready_o      = run & dec_in_ready_i;
    dec_in_valid_o  = run & in_valid_i;
    dec_di_o        = run ? in_data_i : '0;
    dec_out_ready_o = run & (!out_valid_o | out_ready_i) & (load_cnt < total);
    dec_hs          = dec_out_valid_i & dec_out_ready_o;
    host_hs         = out_valid_o & out_ready_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dec_rst_o     <= 1'b1;
      dec_sec_lvl_o <= '0;
      dec_mode_o    <= '0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      beat_cnt_o    <= '0;
      out_valid_o   <= 1'b0;
      out_data_o    <= '0;
      out_last_o    <= 1'b0;
      total         <= '0;
      load_cnt      <= '0;
      rst_cnt       <= '0;
      wd_cnt        <= '0;
`ifdef DILI_SEQ_CHECKSUM_EN
      chk_o         <= '0;
`endif
    end else if (abort_i) begin
      state       <= IDLE;
      dec_rst_o   <= 1'b1;
      done_o      <= 1'b0;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            dec_sec_lvl_o <= sec_lvl_i;
            dec_mode_o    <= encode_mode_i;
            total         <= calc_total(num_poly_i);
            err_o         <= 1'b0;
            beat_cnt_o    <= '0;
            load_cnt      <= '0;
            rst_cnt       <= '0;
`ifdef DILI_SEQ_CHECKSUM_EN
            chk_o         <= '0;
`endif
            state         <= CLR;
          end
        end
        CLR: begin
          if (rst_cnt == RC_W'(RST_CYC - 1)) begin
            dec_rst_o <= 1'b0;
            wd_cnt    <= '0;
            state     <= RUN;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        RUN: begin
          if (host_hs) begin
            beat_cnt_o <= beat_cnt_o + 16'd1;
`ifdef DILI_SEQ_CHECKSUM_EN
            chk_o      <= {chk_o[30:0], chk_o[31]} ^ fold32(out_data_o);
`endif
          end
          // Job end and watchdog expiry both leave through DONE with the decoder reset.
          if (host_hs && out_last_o) begin
            state       <= DONE;
            done_o      <= 1'b1;
            dec_rst_o   <= 1'b1;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
          end else if (!host_hs && wd_cnt == WD_W'(TIMEOUT - 1)) begin
            state       <= DONE;
            done_o      <= 1'b1;
            err_o       <= 1'b1;
            dec_rst_o   <= 1'b1;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
          end else begin
            if (dec_hs) begin
              out_data_o  <= dec_samples_i;
              out_valid_o <= 1'b1;
              out_last_o  <= (load_cnt + 16'd1 == total);
              load_cnt    <= load_cnt + 16'd1;
            end else if (host_hs) begin
              out_valid_o <= 1'b0;
              out_last_o  <= 1'b0;
            end
            wd_cnt <= host_hs ? '0 : wd_cnt + WD_W'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dili_decode_seq.sv
`timescale 1ns/1ps
// Directed bench for dili_decode_seq: decoder beat model, host sink monitor, per-job checks.
module tb_dili_decode_seq;

  localparam int OW = 4;
  localparam int CW = 23;
  localparam int W  = 64;
  localparam int DW = OW * CW;
  localparam int TIMEOUT = 1023;

  logic          clk = 1'b0;
  logic          rst, start_i, abort_i;
  logic [2:0]    sec_lvl_i, encode_mode_i;
  logic [3:0]    num_poly_i;
  logic          busy_o, done_o, err_o;
  logic [15:0]   beat_cnt_o;
  logic          in_valid_i, in_ready_o;
  logic [W-1:0]  in_data_i;
  logic          dec_rst_o;
  logic [2:0]    dec_sec_lvl_o, dec_mode_o;
  logic          dec_in_valid_o, dec_in_ready_i;
  logic [W-1:0]  dec_di_o;
  logic          dec_out_valid_i, dec_out_ready_o;
  logic [DW-1:0] dec_samples_i;
  logic          out_valid_o, out_ready_i;
  logic [DW-1:0] out_data_o;
  logic          out_last_o;
`ifdef DILI_SEQ_CHECKSUM_EN
  logic [31:0]   chk_o;
`endif

  always #5 clk = ~clk;

  dili_decode_seq dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .sec_lvl_i(sec_lvl_i), .encode_mode_i(encode_mode_i), .num_poly_i(num_poly_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .beat_cnt_o(beat_cnt_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .dec_rst_o(dec_rst_o), .dec_sec_lvl_o(dec_sec_lvl_o), .dec_mode_o(dec_mode_o),
    .dec_in_valid_o(dec_in_valid_o), .dec_in_ready_i(dec_in_ready_i), .dec_di_o(dec_di_o),
    .dec_out_valid_i(dec_out_valid_i), .dec_out_ready_o(dec_out_ready_o),
    .dec_samples_i(dec_samples_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o)
`ifdef DILI_SEQ_CHECKSUM_EN
    , .chk_o(chk_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [DW-1:0] mk(input int idx);
    logic [DW-1:0] d;
    for (int k = 0; k < OW; k++) d[k*CW +: CW] = CW'((idx * 37 + k * 1001 + 5) ^ 'h5A5A5);
    return d;
  endfunction

  function automatic logic [DW-1:0] const_beat();
    logic [DW-1:0] d;
    for (int k = 0; k < OW; k++) d[k*CW +: CW] = 23'd1;
    return d;
  endfunction

  function automatic logic [31:0] fold_ref(input logic [DW-1:0] d);
    logic [95:0] p;
    p = {4'b0, d};
    return p[31:0] ^ p[63:32] ^ p[95:64];
  endfunction

  // Decoder model: emits beats gen_idx = 0 .. gen_limit-1.
  logic gen_clr = 1'b0;
  logic gen_const = 1'b0;
  int   gen_idx = 0;
  int   gen_limit = 0;
  always @(posedge clk) begin
    if (gen_clr) gen_idx <= 0;
    else if (dec_out_valid_i && dec_out_ready_o) gen_idx <= gen_idx + 1;
  end
  always_comb begin
    dec_out_valid_i = (gen_idx < gen_limit);
    dec_samples_i   = gen_const ? const_beat() : mk(gen_idx);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Host-side monitor, sampled on the falling edge.
  logic mon_clr = 1'b0;
  int rx_cnt = 0, rx_bad = 0, bp_bad = 0, last_cnt = 0, done_cnt = 0, exp_total = 64;
  int last_hs_edge = 0, done_edge = 0;
  always @(negedge clk) begin
    if (mon_clr) begin
      rx_cnt <= 0; rx_bad <= 0; bp_bad <= 0; last_cnt <= 0; done_cnt <= 0;
      last_hs_edge <= 0; done_edge <= 0;
    end else begin
      if (out_valid_o && out_ready_i) begin
        rx_bad <= rx_bad + int'(!gen_const && (out_data_o !== mk(rx_cnt)))
                         + int'(out_last_o !== (rx_cnt + 1 == exp_total));
        last_cnt <= last_cnt + int'(out_last_o);
        rx_cnt <= rx_cnt + 1;
        last_hs_edge <= cyc + 1;
      end
      if (out_valid_o && !out_ready_i && dec_out_ready_o) bp_bad <= bp_bad + 1;
      if (done_o) begin
        done_cnt <= done_cnt + 1;
        done_edge <= cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_models();
    mon_clr = 1'b1;
    gen_clr = 1'b1;
    step();
    mon_clr = 1'b0;
    gen_clr = 1'b0;
  endtask

  task automatic start_job(input logic [2:0] s, input logic [2:0] m, input logic [3:0] n);
    sec_lvl_i = s; encode_mode_i = m; num_poly_i = n;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit bp, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (bp) out_ready_i = (i % 3 == 0);
      step();
      if (done_o) ok = 1'b1;
    end
    out_ready_i = 1'b1;
  endtask

  task automatic wait_beats(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      step();
      if (rx_cnt >= n) ok = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit ok;
    int n;
`ifdef DILI_SEQ_CHECKSUM_EN
    logic [31:0] exp_chk;
`endif
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    sec_lvl_i = '0; encode_mode_i = '0; num_poly_i = '0;
    in_valid_i = 1'b1; dec_in_ready_i = 1'b1; in_data_i = 64'h0123_4567_89AB_CDEF;
    out_ready_i = 1'b1;
    step(); step();

    // Reset state.
    chk("rst_busy", busy_o, 0);
    chk("rst_dec_rst", dec_rst_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_beat_cnt", beat_cnt_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_dec_in_valid", dec_in_valid_o, 0);
    chk("rst_dec_out_ready", dec_out_ready_o, 0);
    chk("rst_sec_mode", {dec_sec_lvl_o, dec_mode_o}, 0);
    rst = 1'b0;
    step();

    // Basic job, reset timing and input pass-through.
    clr_models();
    exp_total = 64;
    gen_limit = 100000;
    start_job(3'd2, 3'd1, 4'd1);
    chk("clr_busy", busy_o, 1);
    chk("clr_in_ready", in_ready_o, 0);
    chk("cfg_sec", dec_sec_lvl_o, 2);
    chk("cfg_mode", dec_mode_o, 1);
    n = 0;
    while (dec_rst_o === 1'b1 && n < 20) begin
      n++;
      step();
    end
    chk("dec_rst_cycles", n, 4);
    chk("run_in_ready", in_ready_o, 1);
    chk("run_dec_in_valid", dec_in_valid_o, 1);
    chk("run_dec_di", dec_di_o, 64'h0123_4567_89AB_CDEF);
    wait_done(400, 1'b0, ok);
    chk("basic_done_seen", ok, 1);
    step();
    chk("basic_rx_cnt", rx_cnt, 64);
    chk("basic_rx_bad", rx_bad, 0);
    chk("basic_last_cnt", last_cnt, 1);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_beat_cnt", beat_cnt_o, 64);
    chk("basic_idle_busy", busy_o, 0);
    chk("basic_idle_dec_rst", dec_rst_o, 1);
    chk("basic_cfg_hold", dec_sec_lvl_o, 2);

    // Backpressure, two polynomials.
    clr_models();
    exp_total = 128;
    start_job(3'd4, 3'd2, 4'd2);
    wait_done(2000, 1'b1, ok);
    chk("bp_done_seen", ok, 1);
    step();
    chk("bp_rx_cnt", rx_cnt, 128);
    chk("bp_rx_bad", rx_bad, 0);
    chk("bp_ready_when_full", bp_bad, 0);
    chk("bp_last_cnt", last_cnt, 1);
    chk("bp_done_cnt", done_cnt, 1);
    chk("bp_beat_cnt", beat_cnt_o, 128);

    // Watchdog: decoder stalls after 10 beats.
    clr_models();
    exp_total = 64;
    gen_limit = 10;
    start_job(3'd1, 3'd1, 4'd1);
    wait_done(1200, 1'b0, ok);
    chk("wd_done_seen", ok, 1);
    step();
    chk("wd_err", err_o, 1);
    chk("wd_beat_cnt", beat_cnt_o, 10);
    chk("wd_rx_cnt", rx_cnt, 10);
    chk("wd_latency", done_edge - last_hs_edge, TIMEOUT);
    chk("wd_done_cnt", done_cnt, 1);
    chk("wd_out_valid", out_valid_o, 0);

    // Abort colliding with start in mid-run.
    clr_models();
    gen_limit = 100000;
    start_job(3'd3, 3'd4, 4'd1);
    chk("restart_clears_err", err_o, 0);
    wait_beats(20, 200, ok);
    chk("abort_reached_beat20", ok, 1);
    abort_i = 1'b1;
    start_i = 1'b1;
    step();
    abort_i = 1'b0;
    start_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_dec_rst", dec_rst_o, 1);
    chk("abort_out_valid", out_valid_o, 0);
    chk("abort_done", done_o, 0);
    step();
    chk("abort_no_done_pulse", done_cnt, 0);
    chk("abort_err_kept", err_o, 0);
    clr_models();
    start_job(3'd3, 3'd4, 4'd1);
    wait_done(400, 1'b0, ok);
    chk("post_abort_done_seen", ok, 1);
    step();
    chk("post_abort_rx_cnt", rx_cnt, 64);
    chk("post_abort_rx_bad", rx_bad, 0);
    chk("post_abort_beat_cnt", beat_cnt_o, 64);

    // num_poly=0 behaves as 1; a start during RUN is ignored.
    clr_models();
    start_job(3'd5, 3'd3, 4'd0);
    wait_beats(5, 100, ok);
    chk("np0_reached_beat5", ok, 1);
    sec_lvl_i = 3'd7; encode_mode_i = 3'd7; num_poly_i = 4'd3;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("ign_start_sec", dec_sec_lvl_o, 5);
    chk("ign_start_mode", dec_mode_o, 3);
    chk("ign_start_busy", busy_o, 1);
    wait_done(400, 1'b0, ok);
    chk("np0_done_seen", ok, 1);
    step();
    chk("np0_rx_cnt", rx_cnt, 64);
    chk("np0_rx_bad", rx_bad, 0);
    chk("np0_last_cnt", last_cnt, 1);
    chk("np0_beat_cnt", beat_cnt_o, 64);

`ifdef DILI_SEQ_CHECKSUM_EN
    // Checksum over two constant beats.
    clr_models();
    gen_const = 1'b1;
    gen_limit = 2;
    start_job(3'd0, 3'd0, 4'd1);
    chk("chk_cleared", chk_o, 0);
    wait_beats(2, 50, ok);
    chk("chk_reached_beat2", ok, 1);
    step(); step();
    exp_chk = '0;
    for (int b = 0; b < 2; b++) exp_chk = {exp_chk[30:0], exp_chk[31]} ^ fold_ref(const_beat());
    chk("chk_value", chk_o, exp_chk);
    chk("chk_value_const", chk_o, 32'h0180_8063);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    gen_const = 1'b0;
    step();
    chk("chk_hold_after_abort", chk_o, exp_chk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dili_decode_seq.md
Name: dili_decode_seq

Overview:
- Sequencer wrapped around the sample `decoder` in the CW305 DILI top level.
- On a host-register start, it latches the security level and encode mode, then pulses the decoder reset.
- It streams 64-bit packed words from the host stream into the decoder and collects the sample beats (OUTPUT_W×COEFF_W per beat) through a one-entry output register.
- It ends the job after an exact number of polynomials, or on a watchdog timeout.

Parameters:
- OUTPUT_W, 4, coefficients per decoder output beat
- COEFF_W, 23, bits per coefficient
- W, 64, packed input word width
- N_COEFF, 256, coefficients per polynomial (must be a multiple of OUTPUT_W)
- NPOLY_W, 4, width of the polynomial-count field
- RST_CYC, 4, decoder reset hold cycles (≥1)
- TIMEOUT, 1023, maximum RUN cycles allowed without an output beat being accepted

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  single-cycle job start; ignored unless the block is in IDLE
- abort_i  in  1  abort the job from any state
- sec_lvl_i  in  3  security level, captured at start
- encode_mode_i  in  3  encode mode, captured at start
- num_poly_i  in  NPOLY_W  polynomials per job, captured at start
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at job end
- err_o  out  1  sticky timeout flag; cleared at the next accepted start
- beat_cnt_o  out  16  output beats accepted in the current job
- in_valid_i  in  1  host word valid
- in_ready_o  out  1  host word ready
- in_data_i  in  W  host packed word
- dec_rst_o  out  1  decoder reset
- dec_sec_lvl_o  out  3  registered security level driven to the decoder
- dec_mode_o  out  3  registered encode mode driven to the decoder
- dec_in_valid_o  out  1  word valid to the decoder
- dec_in_ready_i  in  1  decoder can accept a word
- dec_di_o  out  W  word to the decoder
- dec_out_valid_i  in  1  decoder sample beat valid
- dec_out_ready_o  out  1  sequencer can accept a sample beat
- dec_samples_i  in  OUTPUT_W*COEFF_W  decoder sample beat
- out_valid_o  out  1  sample beat valid to the host
- out_ready_i  in  1  host accepts a sample beat
- out_data_o  out  OUTPUT_W*COEFF_W  registered sample beat
- out_last_o  out  1  marks the final beat of the job

Behaviour:
- Reset values:
  - Reset applies on the clk edge when rst=1.
  - State goes to IDLE.
  - dec_rst_o=1 (the decoder is held in reset while IDLE).
  - Every other output is 0, including the captured registers and the counters.
- Beat count: TOTAL = num_poly × (N_COEFF/OUTPUT_W), computed once at start. num_poly=0 counts as 1.
- Beat-counter rules:
  - beat_cnt_o increments on each accepted host beat (out_valid_o & out_ready_i).
  - It clears at start.
  - It holds its value through DONE and IDLE.
- IDLE:
  - start_i=1 captures sec_lvl_i, encode_mode_i and num_poly_i and clears err_o.
  - Transition to CLR.
- CLR:
  - dec_rst_o=1 for RST_CYC cycles, then dec_rst_o goes to 0.
  - Transition to RUN.
- RUN input path (combinational):
  - dec_in_valid_o = in_valid_i.
  - in_ready_o = dec_in_ready_i.
  - dec_di_o = in_data_i.
  - The sequencer does not count input words; the decoder consumes a variable number of bits per word.
- Input path outside RUN: in_ready_o=0 and dec_in_valid_o=0.
- Output register:
  - One entry.
  - dec_out_ready_o = RUN & (!out_valid_o | out_ready_i).
  - A decoder handshake loads out_data_o and sets out_valid_o.
  - A host handshake with no new load clears out_valid_o.
  - With out_ready_i=1 held, throughput is one beat per cycle.
  - out_last_o=1 while out_valid_o is high and the held beat is beat number TOTAL.
- RUN exit:
  - After TOTAL beats have been loaded, dec_out_ready_o=0.
  - The final host handshake (on the out_last_o beat) moves the state to DONE.
- DONE:
  - done_o=1 for one cycle.
  - dec_rst_o=1.
  - Next state is IDLE.
- Watchdog:
  - The counter resets on every accepted host beat and on entry to RUN.
  - If it reaches TIMEOUT while in RUN: set err_o, drop any pending output beat (out_valid_o=0), go to DONE.
- Abort:
  - abort_i=1 in any state goes to IDLE on the next edge.
  - Abort sets dec_rst_o=1 and out_valid_o=0.
  - Abort does not pulse done_o and does not change err_o.
  - Abort has priority over start_i and over all RUN events in the same cycle.
- Decoder config: dec_sec_lvl_o and dec_mode_o are driven from the captured registers and hold stable through DONE.
- start_i is ignored in CLR, RUN and DONE.

Optional Feature:
- Macro: DILI_SEQ_CHECKSUM_EN.
- When defined:
  - Adds output port chk_o, 32 bits.
  - Clear to 0 at start.
  - On each accepted host beat, update chk_o = rotl1(chk_o) ^ fold32(out_data_o).
  - fold32 is the XOR of 32-bit slices of out_data_o, with the last slice zero-padded.
  - chk_o holds its value after DONE.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic job and reset timing: rst, then start with sec_lvl=2, mode=1, num_poly=1; a decoder model emits 64 beats; out_ready_i=1 throughout.
  - dec_rst_o is high for exactly 4 cycles after start.
  - 64 beats are accepted and beat 64 carries out_last_o=1.
  - done_o pulses once and beat_cnt_o=64.
- Backpressure: num_poly=2; out_ready_i toggles 1-of-3 cycles.
  - No beat is lost or duplicated; data order is preserved.
  - dec_out_ready_o is low whenever the register is full and out_ready_i=0.
  - beat_cnt_o=128.
- Watchdog: the decoder stops after 10 beats.
  - err_o=1 and done_o pulses exactly TIMEOUT cycles after the 10th accepted beat.
  - beat_cnt_o=10.
  - A later start clears err_o.
- Abort/start collision: assert abort_i together with start_i in mid-RUN at beat 20.
  - Next cycle: IDLE, dec_rst_o=1, out_valid_o=0, no done_o.
  - A start 2 cycles later runs a full 64-beat job.
- num_poly=0 edge case and ignored start: start with num_poly=0.
  - Treated as 1; exactly 64 beats.
  - A start_i pulse during RUN is ignored (the captured values are unchanged).
- Checksum, with DILI_SEQ_CHECKSUM_EN defined: 2 beats, each with all coefficients equal to 0x000001.
  - chk_o matches the reference model value computed by the bench.
